act_vec_seq: RTL and testbench
==============================

Name: act_vec_seq

Overview:
- Request/collect end of the activation lookup interface: it drives in_x/in_valid of a single-cycle activation LUT (tanh_calc style) and consumes out_y/out_valid.
- On start, captures a parallel vector of N pre-activation values and issues them to the LUT one per cycle, element 0 first.
- Collects the in-order responses into a parallel output vector, then pulses done.
- Sits between a layer MAC array and the next layer input buffer, so one LUT instance is shared across all N neurons.

Parameters:
- N, 8, number of vector elements (N ≥ 2).
- IN_DAT_W, 8, pre-activation element width (LUT address width).
- OUT_DAT_W, 8, activation output element width.
- CNT_W, $clog2(N+1), width of the issue/response counters (localparam-derived, not overridable).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous active-high reset.
- start  input  1  begin a sequence; sampled only in IDLE.
- vec_in  input  N*IN_DAT_W  pre-activation vector; element i = vec_in[i*IN_DAT_W +: IN_DAT_W]; captured on accepted start.
- busy  output  1  high from the cycle after an accepted start through the cycle done is high.
- done  output  1  one-cycle pulse when all N results are stored.
- vec_out  output  N*OUT_DAT_W  activation vector; element i at [i*OUT_DAT_W +: OUT_DAT_W]; held until the next completed sequence.
- act_x  output  IN_DAT_W  LUT address (connects to in_x).
- act_valid  output  1  LUT request strobe (connects to in_valid).
- act_y  input  OUT_DAT_W  LUT result (from out_y).
- act_y_valid  input  1  LUT result strobe (from out_valid).

Behaviour:
- Reset values (rst high at a clock edge):
  - state = IDLE; busy = 0; done = 0; act_valid = 0; act_x = 0; vec_out = 0.
  - Issue and response counters = 0; captured vector = 0.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 captures vec_in into an internal register and moves to ISSUE.
  - act_valid stays 0 during the capture cycle.
- ISSUE:
  - Each cycle: act_valid=1, act_x = captured element[iss_cnt], then iss_cnt++.
  - After element N-1 is issued, go to DRAIN.
  - Exactly N consecutive request cycles, no gaps.
- Response collection (valid in ISSUE and DRAIN):
  - Each cycle act_y_valid=1 writes act_y into result slot rsp_cnt, then rsp_cnt++.
  - Responses are in issue order. LUT latency is arbitrary but fixed (≥1); the block never relies on a latency value, only on counting responses.
- DRAIN:
  - act_valid=0.
  - When the N-th response is written, go to DONE.
  - If the N-th response arrives while still in ISSUE (impossible with latency ≥1), it is still handled correctly by the count.
- DONE:
  - One cycle: done=1, busy=1, and vec_out is updated from the result slots in the same cycle done rises.
  - Next state is IDLE.
- busy: registered, equals (state != IDLE).
- Start handling:
  - start while busy is ignored; it is not queued.
  - start in the DONE cycle is ignored.
  - start is accepted in the IDLE cycle after DONE, giving back-to-back sequences with one idle cycle between them.
- vec_in is not sampled after capture, so changes during ISSUE have no effect.
- act_y_valid while in IDLE or DONE (stray/late response) is ignored; no counter or slot changes.
- Responses in excess of N: cannot arise, because transition to DONE happens at count N.
- Reset mid-operation:
  - Aborts immediately; vec_out returns to 0; no done pulse.
  - Responses arriving after reset for already-issued requests are ignored (IDLE rule).
- Counter widths: CNT_W bits; compare against N, no wrap-around within a sequence.
- Latency (LUT latency L): start accepted at cycle 0 → first act_valid at cycle 1 → done at cycle N+L+1.

Test Plan:
- Reset, then N=4, bench LUT model y=~x with latency 1, vec_in elements {0x00,0x01,0x7F,0x80}, start pulse:
  - act_x sequence 0x00,0x01,0x7F,0x80 on cycles 1-4 with act_valid high.
  - done at cycle 6; vec_out elements {0xFF,0xFE,0x80,0x7F}.
- Same vector with LUT latency 3:
  - Identical vec_out; done at cycle 8; busy high cycles 1-8.
- start held high continuously for two sequences (vec_in changed to {0x10,0x20,0x30,0x40} mid-ISSUE):
  - First result unaffected by the change.
  - Second sequence starts in the IDLE cycle after DONE, with one done pulse per sequence.
- Stray act_y_valid=1, act_y=0x55 while IDLE:
  - No state change; vec_out unchanged; no done.
- rst asserted on cycle 3 of a sequence:
  - Next cycle act_valid=0, busy=0, vec_out=0.
  - Late responses are ignored and no done occurs.
  - A new start then completes normally.

Source files
------------

// File: rtl/act_vec_seq.sv
// Feeds N captured pre-activations one per cycle to a shared activation LUT and gathers the in-order results.
// done = N + L + 1 cycles after start (L = LUT latency); start is ignored unless IDLE, and there is no input backpressure.
module act_vec_seq #(
   parameter int N         = 8,
   parameter int IN_DAT_W  = 8,
   parameter int OUT_DAT_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [N*IN_DAT_W-1:0]    vec_in,
   output logic                     busy,
   output logic                     done,
   output logic [N*OUT_DAT_W-1:0]   vec_out,
   output logic [IN_DAT_W-1:0]      act_x,
   output logic                     act_valid,
   input  logic [OUT_DAT_W-1:0]     act_y,
   input  logic                     act_y_valid
);

   localparam int CNT_W = $clog2(N + 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t                   r_state;
   logic [N*IN_DAT_W-1:0]    r_vec_cap;
   logic [N*OUT_DAT_W-1:0]   r_slots;
   logic [N*OUT_DAT_W-1:0]   r_vec_out;
   logic [CNT_W-1:0]         r_iss_cnt;
   logic [CNT_W-1:0]         r_rsp_cnt;
   logic [IN_DAT_W-1:0]      r_act_x;
   logic                     r_act_valid;
   logic                     r_busy;
   logic                     r_done;

   logic [N*OUT_DAT_W-1:0]   w_slots_nxt;
   logic [IN_DAT_W-1:0]      w_iss_elem;
   logic                     w_rsp_en;
   logic                     w_rsp_last;

   // Responses only count while a sequence is in flight; strays in IDLE/DONE are dropped.
   always_comb begin
      w_rsp_en    = act_y_valid && ((r_state == S_ISSUE) || (r_state == S_DRAIN));
      w_rsp_last  = w_rsp_en && (r_rsp_cnt == CNT_W'(N - 1));
      w_slots_nxt = r_slots;
      w_iss_elem  = '0;
      for (int i = 0; i < N; i++) begin
         if (w_rsp_en && (r_rsp_cnt == CNT_W'(i)))
            w_slots_nxt[i*OUT_DAT_W +: OUT_DAT_W] = act_y;
         if (r_iss_cnt == CNT_W'(i))
            w_iss_elem = r_vec_cap[i*IN_DAT_W +: IN_DAT_W];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_vec_cap   <= '0;
         r_slots     <= '0;
         r_vec_out   <= '0;
         r_iss_cnt   <= '0;
         r_rsp_cnt   <= '0;
         r_act_x     <= '0;
         r_act_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_vec_cap   <= vec_in;
                  r_act_x     <= vec_in[IN_DAT_W-1:0];
                  r_act_valid <= 1'b1;
                  r_iss_cnt   <= CNT_W'(1);
                  r_rsp_cnt   <= '0;
                  r_busy      <= 1'b1;
                  r_state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (r_iss_cnt == CNT_W'(N)) begin
                  r_act_valid <= 1'b0;
                  r_state     <= S_DRAIN;
               end else begin
                  r_act_x   <= w_iss_elem;
                  r_iss_cnt <= r_iss_cnt + 1'b1;
               end
               if (w_rsp_last) begin
                  r_act_valid <= 1'b0;
                  r_state     <= S_DONE;
               end
            end
            S_DRAIN: begin
               if (w_rsp_last)
                  r_state <= S_DONE;
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase

         if (w_rsp_en) begin
            r_slots   <= w_slots_nxt;
            r_rsp_cnt <= r_rsp_cnt + 1'b1;
         end
         // Publish the full vector, including the final response, as done rises.
         if (w_rsp_last) begin
            r_vec_out <= w_slots_nxt;
            r_done    <= 1'b1;
         end
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign vec_out   = r_vec_out;
   assign act_x     = r_act_x;
   assign act_valid = r_act_valid;

endmodule

// File: tb/tb_act_vec_seq.sv
// Scoreboard bench for act_vec_seq (N=4) with a behavioural y=~x LUT of selectable latency.
module tb_act_vec_seq;

   localparam int N = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [31:0]   vec_in = '0;
   logic          busy, done, act_valid;
   logic [31:0]   vec_out;
   logic [7:0]    act_x, act_y;
   logic          act_y_valid;

   act_vec_seq #(.N(N), .IN_DAT_W(8), .OUT_DAT_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .vec_in(vec_in),
      .busy(busy), .done(done), .vec_out(vec_out),
      .act_x(act_x), .act_valid(act_valid),
      .act_y(act_y), .act_y_valid(act_y_valid)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // LUT model: y = ~x, latency lat (1..4), plus an injectable stray response.
   int         lat = 1;
   logic [3:0] pv = '0;
   logic [7:0] pd [4];
   logic       stray_v = 1'b0;
   logic [7:0] stray_d = '0;
   always @(posedge clk) begin
      pv    <= {pv[2:0], act_valid};
      pd[0] <= ~act_x;
      for (int i = 1; i < 4; i++) pd[i] <= pd[i-1];
   end
   assign act_y_valid = pv[lat-1] | stray_v;
   assign act_y       = stray_v ? stray_d : pd[lat-1];

   typedef struct { logic [7:0] x; int c; } act_e_t;
   typedef struct { logic [31:0] v; int c; } out_e_t;
   act_e_t exp_act[$];
   out_e_t exp_out[$];

   int n_vec = 0;
   int n_miss = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_seq(input logic [31:0] v, input logic [31:0] y, input int c0,
                           input int l, input int n_iss, input bit full);
      act_e_t a;
      out_e_t o;
      for (int k = 0; k < n_iss; k++) begin
         a.x = v[k*8 +: 8];
         a.c = c0 + 1 + k;
         exp_act.push_back(a);
      end
      if (full) begin
         o.v = y;
         o.c = c0 + N + l + 1;
         exp_out.push_back(o);
      end
   endtask

   // Monitor: every request and every done pulse is matched against the queues.
   always @(negedge clk) begin
      act_e_t a;
      out_e_t o;
      if (act_valid === 1'b1) begin
         if (exp_act.size() == 0) begin
            n_vec++; n_miss++;
            $display("FAIL act_unexpected: got act_x %h at cycle %0d, required no request", act_x, cyc);
         end else begin
            a = exp_act.pop_front();
            chk("act_x", act_x, a.x);
            chk("act_cycle", cyc, a.c);
         end
      end
      if (done === 1'b1) begin
         if (exp_out.size() == 0) begin
            n_vec++; n_miss++;
            $display("FAIL done_unexpected: got done at cycle %0d, required no done", cyc);
         end else begin
            o = exp_out.pop_front();
            chk("vec_out", vec_out, o.v);
            chk("done_cycle", cyc, o.c);
            chk("busy_at_done", busy, 1'b1);
         end
      end
   end

   localparam logic [31:0] VEC_A = 32'h807F0100;   // {0x00,0x01,0x7F,0x80}
   localparam logic [31:0] RES_A = 32'h7F80FEFF;   // {0xFF,0xFE,0x80,0x7F}
   localparam logic [31:0] VEC_B = 32'h40302010;   // {0x10,0x20,0x30,0x40}
   localparam logic [31:0] RES_B = 32'hBFCFDFEF;   // {0xEF,0xDF,0xCF,0xBF}

   initial begin
      int c0;
      tick(); tick();
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_act_valid", act_valid, 1'b0);
      chk("rst_act_x", act_x, 8'h00);
      chk("rst_vec_out", vec_out, 32'h0);
      rst = 1'b0;
      tick();

      // Sequence A, latency 1: start pulse, busy checked cycle by cycle.
      lat = 1; vec_in = VEC_A; start = 1'b1; c0 = cyc;
      push_seq(VEC_A, RES_A, c0, 1, N, 1'b1);
      for (int k = 1; k <= N + 3; k++) begin
         tick();
         start = 1'b0;
         chk("busy_lat1", busy, (k <= N + 2));
      end

      // Same vector, latency 3: busy high cycles 1..8.
      lat = 3; start = 1'b1; c0 = cyc;
      push_seq(VEC_A, RES_A, c0, 3, N, 1'b1);
      for (int k = 1; k <= N + 5; k++) begin
         tick();
         start = 1'b0;
         chk("busy_lat3", busy, (k <= N + 4));
      end

      // start held high for two sequences; vec_in changes during the first ISSUE.
      lat = 1; vec_in = VEC_A; start = 1'b1; c0 = cyc;
      push_seq(VEC_A, RES_A, c0, 1, N, 1'b1);
      push_seq(VEC_B, RES_B, c0 + N + 3, 1, N, 1'b1);
      tick(); tick();
      vec_in = VEC_B;
      while (cyc < c0 + N + 4) tick();
      start = 1'b0;
      while (cyc < c0 + 2 * N + 6) tick();
      chk("b2b_idle_busy", busy, 1'b0);

      // Stray response while IDLE.
      stray_v = 1'b1; stray_d = 8'h55;
      tick();
      stray_v = 1'b0;
      chk("stray_busy", busy, 1'b0);
      chk("stray_done", done, 1'b0);
      chk("stray_vec_out", vec_out, RES_B);
      tick(); tick();
      chk("stray_busy2", busy, 1'b0);
      chk("stray_vec_out2", vec_out, RES_B);

      // Reset on cycle 3 of a latency-3 sequence; its late responses land in IDLE.
      lat = 3; vec_in = VEC_A; start = 1'b1; c0 = cyc;
      push_seq(VEC_A, RES_A, c0, 3, 3, 1'b0);
      tick();
      start = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_act_valid", act_valid, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_vec_out", vec_out, 32'h0);
      repeat (8) tick();
      chk("late_rsp_vec_out", vec_out, 32'h0);
      chk("late_rsp_busy", busy, 1'b0);

      // New sequence completes normally after the abort.
      lat = 1; vec_in = VEC_B; start = 1'b1; c0 = cyc;
      push_seq(VEC_B, RES_B, c0, 1, N, 1'b1);
      tick();
      start = 1'b0;

      for (int k = 0; k < 50 && (exp_out.size() != 0 || exp_act.size() != 0); k++) tick();
      tick(); tick();
      chk("pending_done", exp_out.size(), 0);
      chk("pending_requests", exp_act.size(), 0);
      chk("final_vec_out", vec_out, RES_B);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
